prog_down_timer: RTL and testbench
==================================

Name: prog_down_timer

Overview:
- Parametrised successor to the team's fixed-width loadable down counter, used as the obstacle spawn/spacing timer in the dino game.
- Adds a programmable prescaler, a count enable, one-shot or auto-reload mode, a registered terminal-count pulse and a running flag.
- Sits between the top-level input pins (load value, mode, prescale) and the obstacle generator, which consumes tc_pulse.

Parameters:
WIDTH, 9, width of count, load_value and the internal reload register
PRESCALE_W, 4, width of the prescale input and the internal prescale counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  count enable; when low, the prescaler and count hold
load_en  input  1  synchronous load strobe
load_value  input  WIDTH  value captured on load_en
auto_reload  input  1  1 = periodic (reload on terminal count), 0 = one-shot
prescale  input  PRESCALE_W  one decrement tick every prescale+1 enabled cycles
count  output  WIDTH  current count value
tc_pulse  output  1  one-cycle terminal-count pulse (registered)
running  output  1  timer is armed and counting

Behaviour:
- Design has one clock domain (clock); reset is asynchronous and active-high.
- Reset (async assert) forces: count=0, reload register=0, prescale counter=0, tc_pulse=0, running=0.
- All other updates occur on the rising edge of clock.
- Priority per edge: reset > load_en > tick > hold.
- Load (load_en=1), regardless of en or running:
  - count <= load_value; reload register <= load_value; prescale counter <= 0; tc_pulse <= 0.
  - running <= (load_value != 0).
- Prescaler, active only when en=1 and running=1:
  - tick = (prescale counter >= prescale).
  - On tick, prescale counter <= 0; otherwise it increments by 1.
  - Using >= means a mid-run reduction of prescale takes effect immediately and never leaves a stuck counter.
  - If en=0 or running=0, the prescale counter holds and no tick occurs.
- On tick with count > 1: count <= count - 1; tc_pulse <= 0.
- On tick with count == 1 (terminal count):
  - tc_pulse <= 1 for exactly one cycle, coincident with the count update.
  - auto_reload=1: count <= reload register; running stays 1. Count never shows 0 in periodic mode.
  - auto_reload=0: count <= 0; running <= 0.
  - auto_reload is sampled on the terminal tick edge only.
- Any cycle without a terminal tick: tc_pulse <= 0.
- When count == 0 and running == 0, the timer is idle: ticks are ignored and count holds at 0. No underflow or wrap-around is ever permitted.
- Latency and period:
  - After a load of N ≥ 1 with en held high, tc_pulse is asserted N*(prescale+1) cycles after the load edge.
  - The auto-reload period is reload*(prescale+1) cycles.
- Simultaneous load_en and terminal tick: the load wins and no tc_pulse is generated.
- en deasserted mid-run freezes count and the prescale counter exactly. Resuming continues with no lost or extra ticks.
- Reset asserted mid-run returns all state to reset values immediately. After reset the timer is idle until the next load.
- Width rules: all arithmetic is unsigned at WIDTH / PRESCALE_W bits, with no truncation of load_value.

Test Plan:
- Reset then idle: assert reset mid-count, release, hold en=1 for 20 cycles -> count=0, running=0, tc_pulse never 1.
- One-shot: prescale=0, auto_reload=0, load 5, en=1 -> count goes 5,4,3,2,1,0 on successive cycles; tc_pulse high only on the cycle count becomes 0; running=0 afterwards; count stays 0.
- Auto-reload with prescale: prescale=2, auto_reload=1, load 3 -> tc_pulse every 9 cycles over 5 periods; count sequence 3,3,3,2,2,2,1,1,1,3...; count never 0.
- Enable gating: load 4, prescale=1, drop en for 7 cycles mid-count -> count and prescale counter frozen; total cycles to tc_pulse = 8 + 7.
- Load collision: one-shot load 2, assert load_en with value 6 on the terminal tick cycle -> no tc_pulse, count=6, running=1; the next tc_pulse arrives 6 ticks later.
- Width sweep: WIDTH=16, PRESCALE_W=8, load 0xFFFF with prescale=0 -> no wrap; tc_pulse after 65535 cycles. Load 0 -> running=0 immediately and no pulse.

Source files
------------

// File: rtl/prog_down_timer.sv
// Programmable down timer with prescaler, count enable, one-shot/auto-reload modes,
// a registered terminal-count pulse and a running flag. Drives the obstacle spawn cadence.
module prog_down_timer #(
    parameter int WIDTH      = 9,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load_en,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  auto_reload,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tc_pulse,
    output logic                  running
);

    logic [WIDTH-1:0]      reload_reg;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  active;
    logic                  tick;
    logic                  terminal;
    logic                  load_nonzero;

    // The >= compare lets a mid-run reduction of prescale take effect at once
    // instead of leaving pre_cnt stranded above the new limit.
    assign active       = en && running;
    assign tick         = active && (pre_cnt >= prescale);
    assign terminal     = tick && (count == WIDTH'(1));
    assign load_nonzero = (load_value != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count      <= '0;
            reload_reg <= '0;
            pre_cnt    <= '0;
            tc_pulse   <= 1'b0;
            running    <= 1'b0;
        end else if (load_en) begin
            count      <= load_value;
            reload_reg <= load_value;
            pre_cnt    <= '0;
            tc_pulse   <= 1'b0;
            running    <= load_nonzero;
        end else begin
            tc_pulse <= 1'b0;

            if (active) begin
                if (tick) begin
                    pre_cnt <= '0;
                end else begin
                    pre_cnt <= pre_cnt + PRESCALE_W'(1);
                end
            end

            // Periodic mode jumps straight from 1 to the reload value, so count never shows 0.
            if (terminal) begin
                tc_pulse <= 1'b1;
                if (auto_reload) begin
                    count <= reload_reg;
                end else begin
                    count   <= '0;
                    running <= 1'b0;
                end
            end else if (tick && (count > WIDTH'(1))) begin
                count <= count - WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_down_timer.sv
// Directed self-checking bench for prog_down_timer: default 9-bit instance for the
// functional cases, plus a 16-bit instance for the full-range width sweep.
module tb_prog_down_timer;

    localparam int W_A  = 9;
    localparam int P_A  = 4;
    localparam int W_B  = 16;
    localparam int P_B  = 8;

    logic           clock;
    logic           reset;

    logic           en_a;
    logic           load_en_a;
    logic [W_A-1:0] load_value_a;
    logic           auto_reload_a;
    logic [P_A-1:0] prescale_a;
    logic [W_A-1:0] count_a;
    logic           tc_pulse_a;
    logic           running_a;

    logic           en_b;
    logic           load_en_b;
    logic [W_B-1:0] load_value_b;
    logic           auto_reload_b;
    logic [P_B-1:0] prescale_b;
    logic [W_B-1:0] count_b;
    logic           tc_pulse_b;
    logic           running_b;

    int n_compared;
    int n_mismatched;

    prog_down_timer #(.WIDTH(W_A), .PRESCALE_W(P_A)) dut_a (
        .clock       (clock),
        .reset       (reset),
        .en          (en_a),
        .load_en     (load_en_a),
        .load_value  (load_value_a),
        .auto_reload (auto_reload_a),
        .prescale    (prescale_a),
        .count       (count_a),
        .tc_pulse    (tc_pulse_a),
        .running     (running_a)
    );

    prog_down_timer #(.WIDTH(W_B), .PRESCALE_W(P_B)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .en          (en_b),
        .load_en     (load_en_b),
        .load_value  (load_value_b),
        .auto_reload (auto_reload_b),
        .prescale    (prescale_b),
        .count       (count_b),
        .tc_pulse    (tc_pulse_b),
        .running     (running_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One load edge on instance A; load_en drops again before the next edge.
    task automatic load_a(input logic [W_A-1:0] value);
        load_value_a = value;
        load_en_a    = 1'b1;
        step();
        load_en_a    = 1'b0;
    endtask

    task automatic wait_tc_a(input int bound, output int cycles);
        cycles = 0;
        while (cycles < bound) begin
            step();
            cycles++;
            if (tc_pulse_a) return;
        end
    endtask

    task automatic wait_tc_b(input int bound, output int cycles);
        cycles = 0;
        while (cycles < bound) begin
            step();
            cycles++;
            if (tc_pulse_b) return;
        end
    endtask

    initial begin
        int cycles;
        int tc_seen;
        int zero_seen;

        n_compared    = 0;
        n_mismatched  = 0;
        reset         = 1'b1;
        en_a          = 1'b0;
        load_en_a     = 1'b0;
        load_value_a  = '0;
        auto_reload_a = 1'b0;
        prescale_a    = '0;
        en_b          = 1'b0;
        load_en_b     = 1'b0;
        load_value_b  = '0;
        auto_reload_b = 1'b0;
        prescale_b    = '0;

        step();
        step();
        check_output("reset_count", count_a, 0);
        check_output("reset_running", running_a, 0);
        check_output("reset_tc", tc_pulse_a, 0);
        reset = 1'b0;
        step();

        // Reset mid-count, then confirm the timer stays idle with en high.
        en_a = 1'b1;
        load_a(9'd5);
        step();
        check_output("pre_reset_count", count_a, 4);
        #2 reset = 1'b1;
        #1;
        check_output("async_reset_count", count_a, 0);
        check_output("async_reset_running", running_a, 0);
        step();
        reset   = 1'b0;
        tc_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tc_pulse_a) tc_seen++;
        end
        check_output("idle_count", count_a, 0);
        check_output("idle_running", running_a, 0);
        check_output("idle_tc_seen", tc_seen, 0);

        // One-shot, prescale 0.
        prescale_a    = 4'd0;
        auto_reload_a = 1'b0;
        load_a(9'd5);
        check_output("oneshot_load_count", count_a, 5);
        check_output("oneshot_load_running", running_a, 1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_output("oneshot_count", count_a, 5 - k);
            check_output("oneshot_tc", tc_pulse_a, (k == 5) ? 1 : 0);
        end
        step();
        step();
        check_output("oneshot_done_count", count_a, 0);
        check_output("oneshot_done_running", running_a, 0);
        check_output("oneshot_done_tc", tc_pulse_a, 0);

        // Auto-reload, prescale 2, reload 3: period of 9 cycles, count never 0.
        prescale_a    = 4'd2;
        auto_reload_a = 1'b1;
        load_a(9'd3);
        check_output("auto_load_count", count_a, 3);
        zero_seen = 0;
        for (int k = 1; k <= 45; k++) begin
            step();
            if (count_a == 0) zero_seen++;
            check_output("auto_count", count_a, 3 - ((k / 3) % 3));
            check_output("auto_tc", tc_pulse_a, (k % 9 == 0) ? 1 : 0);
        end
        check_output("auto_zero_seen", zero_seen, 0);
        check_output("auto_running", running_a, 1);

        // Enable gating: 8 enabled cycles plus a 7-cycle freeze.
        auto_reload_a = 1'b0;
        prescale_a    = 4'd1;
        load_a(9'd4);
        cycles  = 0;
        tc_seen = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            cycles++;
        end
        check_output("gate_before_freeze", count_a, 3);
        en_a = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            cycles++;
            if (tc_pulse_a) tc_seen++;
        end
        check_output("gate_frozen_count", count_a, 3);
        check_output("gate_frozen_tc", tc_seen, 0);
        en_a = 1'b1;
        step();
        cycles++;
        check_output("gate_resume_tick", count_a, 2);
        wait_tc_a(40, tc_seen);
        check_output("gate_total_cycles", cycles + tc_seen, 15);

        // Load collides with the terminal tick: load wins, no pulse.
        prescale_a    = 4'd0;
        auto_reload_a = 1'b0;
        load_a(9'd2);
        step();
        check_output("collide_pre_count", count_a, 1);
        load_value_a = 9'd6;
        load_en_a    = 1'b1;
        step();
        load_en_a    = 1'b0;
        check_output("collide_tc", tc_pulse_a, 0);
        check_output("collide_count", count_a, 6);
        check_output("collide_running", running_a, 1);
        wait_tc_a(20, cycles);
        check_output("collide_next_tc_cycles", cycles, 6);

        // Width sweep on the 16-bit instance.
        en_b          = 1'b1;
        prescale_b    = 8'd0;
        auto_reload_b = 1'b0;
        load_value_b  = 16'hFFFF;
        load_en_b     = 1'b1;
        step();
        load_en_b     = 1'b0;
        check_output("wide_load_count", count_b, 16'hFFFF);
        wait_tc_b(70000, cycles);
        check_output("wide_tc_cycles", cycles, 65535);
        check_output("wide_done_count", count_b, 0);
        check_output("wide_done_running", running_b, 0);

        load_value_b = 16'h0000;
        load_en_b    = 1'b1;
        step();
        load_en_b    = 1'b0;
        check_output("zero_load_running", running_b, 0);
        check_output("zero_load_count", count_b, 0);
        tc_seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (tc_pulse_b) tc_seen++;
        end
        check_output("zero_load_tc_seen", tc_seen, 0);
        check_output("zero_load_hold", count_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
